// File: rtl/id_ctrl_stage_if.sv
// Bundle of the IF/ID -> ID/EX signals handled by the ID control stage.
// The IF side drives the instruction and flush request. The ID stage drives
// the ready signal, the registered control bundle and the performance counters.
interface id_ctrl_stage_if #(
   parameter int RADDR_W = 5,
   parameter int CNT_W   = 16
);
   logic               valid_i;
   logic [31:0]        instr_i;
   logic               flush_i;
   logic               ready_o;
   logic               valid_o;
   logic               reg_write_o;
   logic               alu_src_o;
   logic               alu_signed_o;
   logic               branch_o;
   logic               jump_o;
   logic               mem_read_o;
   logic               mem_write_o;
   logic [2:0]         alu_op_o;
   logic [1:0]         reg_dst_o;
   logic [1:0]         branch_type_o;
   logic [1:0]         mem_to_reg_o;
   logic [RADDR_W-1:0] wr_addr_o;
   logic               illegal_o;
   logic [CNT_W-1:0]   issue_cnt_o;
   logic [CNT_W-1:0]   bubble_cnt_o;

   // Fetch/EX side: presents instructions and flushes, observes the ID stage
   modport master (
      output valid_i, instr_i, flush_i,
      input  ready_o, valid_o, reg_write_o, alu_src_o, alu_signed_o,
             branch_o, jump_o, mem_read_o, mem_write_o, alu_op_o,
             reg_dst_o, branch_type_o, mem_to_reg_o, wr_addr_o,
             illegal_o, issue_cnt_o, bubble_cnt_o
   );

   // ID stage side
   modport slave (
      input  valid_i, instr_i, flush_i,
      output ready_o, valid_o, reg_write_o, alu_src_o, alu_signed_o,
             branch_o, jump_o, mem_read_o, mem_write_o, alu_op_o,
             reg_dst_o, branch_type_o, mem_to_reg_o, wr_addr_o,
             illegal_o, issue_cnt_o, bubble_cnt_o
   );
endinterface

// File: rtl/id_ctrl_stage.sv
// Registered instruction-decode control stage.
// Decodes the opcode into the control bundle, resolves the destination
// register and registers both into the ID/EX slot. It inserts a single
// bubble on a load-use hazard, kills the ID instruction on a flush from EX,
// flags undefined opcodes and counts issued instructions and bubbles.
module id_ctrl_stage #(
   parameter int OP_W      = 6,
   parameter int RADDR_W   = 5,
   parameter int CNT_W     = 16,
   parameter int HAZARD_EN = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   id_ctrl_stage_if.slave  bus
);

   typedef struct packed {
      logic       reg_write;
      logic       alu_src;
      logic       alu_signed;
      logic       branch;
      logic       jump;
      logic       mem_read;
      logic       mem_write;
      logic [2:0] alu_op;
      logic [1:0] reg_dst;
      logic [1:0] branch_type;
      logic [1:0] mem_to_reg;
      logic       illegal;
   } ctl_t;

   typedef struct packed {
      ctl_t ctl;
      logic rs_used;
      logic rt_used;
   } dec_t;

   // Opcode -> control bundle, plus which source fields the instruction reads.
   function automatic dec_t decode(input logic [OP_W-1:0] op);
      dec_t d;
      d         = '0;
      d.rs_used = 1'b1;
      case (op)
         OP_W'(0): begin
            d.ctl.reg_write = 1'b1;
            d.ctl.reg_dst   = 2'b01;
            d.ctl.alu_op    = 3'b010;
            d.rt_used       = 1'b1;
         end
         OP_W'(1): begin
            d.ctl.branch      = 1'b1;
            d.ctl.alu_op      = 3'b001;
            d.ctl.branch_type = 2'b10;
         end
         OP_W'(4): begin
            d.ctl.branch      = 1'b1;
            d.ctl.alu_op      = 3'b001;
            d.ctl.branch_type = 2'b00;
            d.rt_used         = 1'b1;
         end
         OP_W'(5): begin
            d.ctl.branch      = 1'b1;
            d.ctl.alu_op      = 3'b001;
            d.ctl.branch_type = 2'b01;
            d.rt_used         = 1'b1;
         end
         OP_W'(6): begin
            d.ctl.branch      = 1'b1;
            d.ctl.alu_op      = 3'b101;
            d.ctl.branch_type = 2'b11;
         end
         OP_W'(2): begin
            d.ctl.jump = 1'b1;
            d.rs_used  = 1'b0;
         end
         OP_W'(3): begin
            d.ctl.jump       = 1'b1;
            d.ctl.reg_write  = 1'b1;
            d.ctl.reg_dst    = 2'b10;
            d.ctl.mem_to_reg = 2'b11;
            d.rs_used        = 1'b0;
         end
         OP_W'(8): begin
            d.ctl.reg_write = 1'b1;
            d.ctl.alu_src   = 1'b1;
            d.ctl.alu_op    = 3'b000;
         end
         OP_W'(15): begin
            d.ctl.reg_write = 1'b1;
            d.ctl.alu_src   = 1'b1;
            d.ctl.alu_op    = 3'b000;
            d.rs_used       = 1'b0;
         end
         OP_W'(9): begin
            d.ctl.reg_write  = 1'b1;
            d.ctl.alu_src    = 1'b1;
            d.ctl.alu_signed = 1'b1;
            d.ctl.alu_op     = 3'b100;
         end
         OP_W'(13): begin
            d.ctl.reg_write  = 1'b1;
            d.ctl.alu_src    = 1'b1;
            d.ctl.alu_signed = 1'b1;
            d.ctl.alu_op     = 3'b011;
         end
         OP_W'(35): begin
            d.ctl.reg_write  = 1'b1;
            d.ctl.alu_src    = 1'b1;
            d.ctl.mem_read   = 1'b1;
            d.ctl.mem_to_reg = 2'b01;
         end
         OP_W'(43): begin
            d.ctl.alu_src   = 1'b1;
            d.ctl.mem_write = 1'b1;
            d.rt_used       = 1'b1;
         end
         default: begin
            d.ctl.illegal = 1'b1;
         end
      endcase
      return d;
   endfunction

   // Destination register: rd for R-type, the link register for jal, rt
   // otherwise. Instructions that do not write report register 0.
   function automatic logic [RADDR_W-1:0] resolve_wr(
      input ctl_t               c,
      input logic [RADDR_W-1:0] rt,
      input logic [RADDR_W-1:0] rd
   );
      logic [RADDR_W-1:0] a;
      case (c.reg_dst)
         2'b01:   a = rd;
         2'b10:   a = '1;
         default: a = rt;
      endcase
      return c.reg_write ? a : '0;
   endfunction

   // Stage 0: combinational decode of the instruction presented by IF
   logic [OP_W-1:0]    op_p0;
   logic [RADDR_W-1:0] rs_p0;
   logic [RADDR_W-1:0] rt_p0;
   logic [RADDR_W-1:0] rd_p0;
   dec_t               dec_p0;
   logic [RADDR_W-1:0] wr_p0;
   logic               use_hit_p0;
   logic               hazard_p0;
   logic               unused_instr_bits;

   // Stage 1: ID/EX slot
   logic               vld_p1;
   ctl_t               ctl_p1;
   logic [RADDR_W-1:0] wr_p1;
   logic [CNT_W-1:0]   issue_p1;
   logic [CNT_W-1:0]   bubble_p1;

   assign op_p0  = bus.instr_i[31 -: OP_W];
   assign rs_p0  = bus.instr_i[21 +: RADDR_W];
   assign rt_p0  = bus.instr_i[16 +: RADDR_W];
   assign rd_p0  = bus.instr_i[11 +: RADDR_W];
   assign dec_p0 = decode(op_p0);
   assign wr_p0  = resolve_wr(dec_p0.ctl, rt_p0, rd_p0);

   // Not every instruction bit feeds the decode (function/shamt/immediate)
   assign unused_instr_bits = ^bus.instr_i;

   // A load in the ID/EX slot whose result a source of the incoming
   // instruction needs. Register 0 never carries a dependency.
   assign use_hit_p0 = (dec_p0.rs_used && (rs_p0 == wr_p1)) ||
                       (dec_p0.rt_used && (rt_p0 == wr_p1));
   assign hazard_p0  = (HAZARD_EN != 0) && bus.valid_i && vld_p1 &&
                       ctl_p1.mem_read && (wr_p1 != '0) && use_hit_p0;

   // A flush consumes the instruction even when it would have stalled
   assign bus.ready_o = !rst_i && !(hazard_p0 && !bus.flush_i);

   // ID/EX slot update: reset > flush > load-use bubble > normal issue
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_p1    <= 1'b0;
         ctl_p1    <= '0;
         wr_p1     <= '0;
         issue_p1  <= '0;
         bubble_p1 <= '0;
      end else if (bus.flush_i) begin
         vld_p1 <= 1'b0;
         ctl_p1 <= '0;
         wr_p1  <= '0;
      end else if (hazard_p0) begin
         vld_p1    <= 1'b0;
         ctl_p1    <= '0;
         wr_p1     <= '0;
         bubble_p1 <= bubble_p1 + CNT_W'(1);
      end else if (bus.valid_i) begin
         vld_p1   <= 1'b1;
         ctl_p1   <= dec_p0.ctl;
         wr_p1    <= wr_p0;
         issue_p1 <= issue_p1 + CNT_W'(1);
      end else begin
         vld_p1 <= 1'b0;
         ctl_p1 <= '0;
         wr_p1  <= '0;
      end
   end

   assign bus.valid_o       = vld_p1;
   assign bus.reg_write_o   = ctl_p1.reg_write;
   assign bus.alu_src_o     = ctl_p1.alu_src;
   assign bus.alu_signed_o  = ctl_p1.alu_signed;
   assign bus.branch_o      = ctl_p1.branch;
   assign bus.jump_o        = ctl_p1.jump;
   assign bus.mem_read_o    = ctl_p1.mem_read;
   assign bus.mem_write_o   = ctl_p1.mem_write;
   assign bus.alu_op_o      = ctl_p1.alu_op;
   assign bus.reg_dst_o     = ctl_p1.reg_dst;
   assign bus.branch_type_o = ctl_p1.branch_type;
   assign bus.mem_to_reg_o  = ctl_p1.mem_to_reg;
   assign bus.wr_addr_o     = wr_p1;
   assign bus.illegal_o     = ctl_p1.illegal;
   assign bus.issue_cnt_o   = issue_p1;
   assign bus.bubble_cnt_o  = bubble_p1;

endmodule

// File: doc/id_ctrl_stage.md
# id_ctrl_stage

Registered, parameterised successor to the single-cycle control decoder: sits between the IF/ID and ID/EX boundaries of the pipelined CPU. Decodes the instruction opcode into the full control bundle, resolves the destination register, and registers it into the ID/EX stage. Detects load-use hazards and inserts one-cycle bubbles, honours branch flushes from EX, flags illegal opcodes, and keeps issue/bubble performance counters.

## Interface
- OP_W, 6, opcode width (instr bits [31:26]); decode table below is fixed for 6.
- RADDR_W, 5, register address width.
- CNT_W, 16, width of performance counters.
- HAZARD_EN, 1, 1 = load-use stall enabled; 0 = never stall (ready_o tracks reset only).

- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  instr_i holds a valid instruction.
- instr_i  in  32  instruction; rs=[25:21], rt=[20:16], rd=[15:11].
- flush_i  in  1  branch/jump taken in EX; kill instruction in ID.
- ready_o  out  1  ID accepts instr_i this cycle (IF advances).
- valid_o  out  1  ID/EX slot holds a live instruction.
- reg_write_o, alu_src_o, alu_signed_o, branch_o, jump_o, mem_read_o, mem_write_o  out  1 each  control bits.
- alu_op_o  out  3; reg_dst_o  out  2; branch_type_o  out  2; mem_to_reg_o  out  2.
- wr_addr_o  out  RADDR_W  resolved destination register.
- illegal_o  out  1  registered instruction had an undefined opcode.
- issue_cnt_o, bubble_cnt_o  out  CNT_W  performance counters.

## Operation
- Decode (opcode decimal): 0 R-type: reg_write, reg_dst=01, alu_op=010. 1 bltz, 4 beq, 5 bne: branch, alu_op=001. 6 ble: branch, alu_op=101. 2 j: jump. 3 jal: jump, reg_write, reg_dst=10, mem_to_reg=11. 8 addi, 15 li: reg_write, alu_src, alu_op=000. 9 sltiu: reg_write, alu_src, alu_signed, alu_op=100. 13 ori: reg_write, alu_src, alu_signed, alu_op=011. 35 lw: reg_write, alu_src, mem_read, mem_to_reg=01. 43 sw: alu_src, mem_write. Unlisted fields 0.
- branch_type: beq 00, bne 01, bltz 10, ble 11; 00 for non-branches.
- Any other opcode: all control bits 0, illegal_o=1, valid_o=1 (EX raises the exception).
- wr_addr: reg_dst 01 -> rd; 10 -> 31; 00 -> rt. Forced 0 when reg_write=0.
- Source use: rs used by all except 2, 3, 15; rt used by 0, 4, 5, 43.
- Load-use hazard (HAZARD_EN=1): hazard = valid_i & valid_o & mem_read_o & wr_addr_o!=0 & (wr_addr_o equals a used source of instr_i).
- ready_o = !rst_i & !(hazard & !flush_i).
- Next-state priority: rst_i > flush_i > hazard > normal.
  - flush_i: valid_o<=0, controls<=0, illegal_o<=0; instr_i consumed and discarded (ready_o=1).
  - hazard: bubble; valid_o<=0, controls<=0, bubble_cnt+1; instr_i held by IF and re-presented next cycle.
  - normal: valid_o<=valid_i; controls<=decode(instr_i) if valid_i else 0; issue_cnt+1 if valid_i.
- Counters wrap modulo 2^CNT_W; no saturation.
- Hazard lasts exactly one cycle: the bubble clears mem_read_o, so the retry issues.

## Timing
- Latency: one cycle from accepted instr_i to registered outputs.
- Reset: every output 0 (valid_o, all controls, wr_addr_o, illegal_o, both counters); ready_o=0 while rst_i high, 1 first cycle after.
- Reset mid-stall: stall dropped, held instruction discarded by IF reset.
- ready_o and hazard are combinational on instr_i and registered state; no other comb path input->output.
- flush_i and hazard in same cycle: flush wins, bubble_cnt not incremented.
- valid_i=0: outputs become bubble, no counter change.

## Test plan
- Reset then lw $8 (0x8C080000) then add $9,$8,$8 -> cycle 2 ready_o=0, valid_o=0 bubble, bubble_cnt=1; cycle 3 add issues, wr_addr_o=9, issue_cnt=2.
- lw to $0 followed by consumer of $0 -> no stall, ready_o stays 1, bubble_cnt=0.
- jal (opcode 3) -> reg_write=1, reg_dst=10, wr_addr_o=31, mem_to_reg=11, jump=1.
- Opcode 0x3F -> valid_o=1, illegal_o=1, all controls 0, wr_addr_o=0.
- Hazard cycle with flush_i=1 -> ready_o=1, valid_o=0 next, bubble_cnt unchanged; flush alone after beq -> slot killed.
- CNT_W=4, 17 issues -> issue_cnt_o=1 (wrap); assert rst_i mid-stream -> all outputs 0 next edge.
